conv_fprop2_mul_acc_pipe: RTL and testbench

CONV_FPROP2_MUL_ACC_PIPE -- requirements
Module: conv_fprop2_mul_acc_pipe

---
 rtl/conv_fprop2_mul_acc_pipe_if.sv | 27 ++
 rtl/conv_fprop2_mul_acc_pipe.sv | 128 ++++++++++++
 tb/tb_conv_fprop2_mul_acc_pipe.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/conv_fprop2_mul_acc_pipe_if.sv
// Operand/result bundle for the pipelined multiply-accumulate unit.
// The master drives operands and tags; the slave (the datapath) returns results.
interface conv_fprop2_mul_acc_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 32,
    parameter int unsigned DOUT_WIDTH = 32
);
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  sgn;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, sgn, acc_en, acc_clr,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, sgn, acc_en, acc_clr,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/conv_fprop2_mul_acc_pipe.sv
// Pipelined signed/unsigned multiplier with optional accumulate and sticky overflow.
// Latency is NUM_STAGE+1 ce-enabled cycles; ce=0 freezes every register.
module conv_fprop2_mul_acc_pipe #(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 32,
    parameter int unsigned DOUT_WIDTH = 32,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned ACC_WIDTH  = 48
) (
    input logic                         clk,
    input logic                         reset,
    input logic                         ce,
    conv_fprop2_mul_acc_pipe_if.slave   bus
);
    localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;
    // One guard bit above the wider of accumulator and product holds any exact sum.
    localparam int unsigned EW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
    localparam int unsigned LS = NUM_STAGE - 1;

    logic [PW-1:0]        a_w, b_w, prod_in;
    logic [PW-1:0]        prod_q [NUM_STAGE];
    logic [PW-1:0]        prod_d [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q, vld_d, sgn_q, sgn_d, en_q, en_d, clr_q, clr_d;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;

    logic [EW-1:0]          base_ext, prod_ext, sum;
    logic [EW-ACC_WIDTH:0]  sum_hi;
    logic                   add_ovf;
    logic                   v_l, s_l, e_l, c_l;

    // Extending both operands to PW bits makes the low PW product bits exact for either mode.
    always_comb begin
        a_w     = {{DIN1_WIDTH{bus.sgn & bus.din0[DIN0_WIDTH-1]}}, bus.din0};
        b_w     = {{DIN0_WIDTH{bus.sgn & bus.din1[DIN1_WIDTH-1]}}, bus.din1};
        prod_in = a_w * b_w;
    end

    always_comb begin
        prod_d = prod_q;
        vld_d  = vld_q;
        sgn_d  = sgn_q;
        en_d   = en_q;
        clr_d  = clr_q;
        if (ce) begin
            prod_d[0] = prod_in;
            vld_d[0]  = bus.in_valid;
            sgn_d[0]  = bus.sgn;
            en_d[0]   = bus.acc_en;
            clr_d[0]  = bus.acc_clr;
            for (int i = 1; i < int'(NUM_STAGE); i++) begin
                prod_d[i] = prod_q[i-1];
                vld_d[i]  = vld_q[i-1];
                sgn_d[i]  = sgn_q[i-1];
                en_d[i]   = en_q[i-1];
                clr_d[i]  = clr_q[i-1];
            end
        end
    end

    always_comb begin
        v_l = vld_q[LS];
        s_l = sgn_q[LS];
        e_l = en_q[LS];
        c_l = clr_q[LS];

        base_ext = {{(EW-ACC_WIDTH){s_l & acc_q[ACC_WIDTH-1]}}, acc_q};
        if (c_l) begin
            base_ext = '0;
        end
        prod_ext = {{(EW-PW){s_l & prod_q[LS][PW-1]}}, prod_q[LS]};
        sum      = base_ext + prod_ext;

        // Signed: every bit from ACC_WIDTH-1 up must match; unsigned: nothing above ACC_WIDTH-1.
        sum_hi  = sum[EW-1:ACC_WIDTH-1];
        add_ovf = s_l ? ((|sum_hi) & ~(&sum_hi)) : (|sum_hi[EW-ACC_WIDTH:1]);

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = v_l;
            if (v_l) begin
                if (e_l) begin
                    acc_d  = sum[ACC_WIDTH-1:0];
                    ovf_d  = (ovf_q & ~c_l) | add_ovf;
                    dout_d = sum[DOUT_WIDTH-1:0];
                end else begin
                    dout_d = prod_ext[DOUT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_STAGE); i++) begin
                prod_q[i] <= '0;
            end
            vld_q       <= '0;
            sgn_q       <= '0;
            en_q        <= '0;
            clr_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            vld_q       <= vld_d;
            sgn_q       <= sgn_d;
            en_q        <= en_d;
            clr_q       <= clr_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_conv_fprop2_mul_acc_pipe.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor pops and compares
// them (value, ovf and arrival cycle) whenever the unit presents a fresh result.
module tb_conv_fprop2_mul_acc_pipe;
    localparam int unsigned NS = 2;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    conv_fprop2_mul_acc_pipe_if #(
        .DIN0_WIDTH(32),
        .DIN1_WIDTH(32),
        .DOUT_WIDTH(32)
    ) bus ();

    conv_fprop2_mul_acc_pipe #(
        .DIN0_WIDTH(32),
        .DIN1_WIDTH(32),
        .DOUT_WIDTH(32),
        .NUM_STAGE (NS),
        .ACC_WIDTH (48)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic        o;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    logic        ce_s, rst_s;

    // Counts ce-enabled edges so latency can be checked in enabled cycles.
    always @(posedge clk) begin
        if (ce && !reset) cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        ce_s  = ce;
        rst_s = reset;
        #1;
        if (ce_s && !rst_s && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, " dout"}, 64'(bus.dout), 64'(e.d));
                chk({e.name, " ovf"}, 64'(bus.ovf), 64'(e.o));
                chk({e.name, " cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic en, input logic clr,
                      input logic [31:0] xd, input logic xo, input bit push);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        bus.sgn      = s;
        bus.acc_en   = en;
        bus.acc_clr  = clr;
        if (push) begin
            e.d    = xd;
            e.o    = xo;
            e.cyc  = cyc + 1 + NS;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset        = 1'b1;
        ce           = 1'b1;
        bus.in_valid = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        bus.sgn      = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset dout", 64'(bus.dout), 64'd0);
        chk("reset ovf", 64'(bus.ovf), 64'd0);
        reset = 1'b0;

        op("smul", 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFEB, 1'b0, 1'b1);
        op("umul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1);
        op("smul_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1);

        op("acc0", 32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b1);
        op("acc1", 32'd4, 32'd5, 1'b1, 1'b1, 1'b0, 32'd26, 1'b0, 1'b1);
        op("acc2", 32'hFFFF_FFFF, 32'd6, 1'b1, 1'b1, 1'b0, 32'd20, 1'b0, 1'b1);
        // Invalid slot carrying accumulate/clear tags must not touch the accumulator.
        bus.in_valid = 1'b0;
        bus.acc_en   = 1'b1;
        bus.acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        op("mul_clr_ign", 32'd3, 32'd3, 1'b1, 1'b0, 1'b1, 32'd9, 1'b0, 1'b1);
        op("acc_after", 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 32'd21, 1'b0, 1'b1);

        op("stall_a", 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 32'd30, 1'b0, 1'b1);
        op("stall_b", 32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 32'd56, 1'b0, 1'b1);
        ce           = 1'b0;
        bus.in_valid = 1'b1;
        bus.din0     = 32'd1000;
        bus.din1     = 32'd1000;
        bus.acc_en   = 1'b1;
        bus.acc_clr  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("stall out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall dout", 64'(bus.dout), 64'd21);
            chk("stall ovf", 64'(bus.ovf), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.acc_en   = 1'b0;
        bus.acc_clr  = 1'b0;
        ce           = 1'b1;
        op("post_stall", 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 32'd22, 1'b0, 1'b1);

        op("ov_seed", 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        op("ov_wrap", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 1'b1);
        op("ov_stay", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 1'b1);
        op("ov_clr", 32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b1);
        op("ov_again", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1, 1'b1);

        // Two operands in flight get discarded by reset.
        op("flight1", 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        op("flight2", 32'd8, 32'd8, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset dout", 64'(bus.dout), 64'd0);
        chk("midreset ovf", 64'(bus.ovf), 64'd0);
        reset = 1'b0;
        idle(6);

        op("post_rst", 32'd2, 32'd3, 1'b1, 1'b1, 1'b0, 32'd6, 1'b0, 1'b1);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
